// File: rtl/quantization_unit.sv
// quantization_unit
//   Three-stage requantizer: data_out = clamp(round((data_in * scale_recip) >> shift) + zero_point).
//   S1 multiplies, S2 rounds (half toward +inf) and shifts, S3 adds the zero
//   point and clamps to [QMIN, QMAX]. Valid/ready handshake on both sides with
//   per-stage valid bits; the pipeline holds up to three items under stall.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   data_in/valid_in/ready_in    input stream (signed 16-bit samples)
//   scale_recip, shift, zero_point  per-item config, captured with data_in
//   data_out/valid_out/ready_out output stream (sign-extended quantized value)
//   sat_out                  current data_out was clamped
//   sat_count, sat_clear     count of delivered clamped results, sync clear
//   busy                     any stage holds a valid item
module quantization_unit #(
  parameter int QMIN = -128,
  parameter int QMAX = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        valid_in,
  output logic        ready_in,
  input  logic [15:0] scale_recip,
  input  logic [3:0]  shift,
  input  logic [15:0] zero_point,
  output logic [15:0] data_out,
  output logic        valid_out,
  input  logic        ready_out,
  output logic        sat_out,
  output logic [15:0] sat_count,
  input  logic        sat_clear,
  output logic        busy
);

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int SUM_W  = PROD_W + 1;

  localparam logic signed [SUM_W-1:0] QMIN_S = SUM_W'(QMIN);
  localparam logic signed [SUM_W-1:0] QMAX_S = SUM_W'(QMAX);

  // Adds half an LSB of the shifted result, then floors: ties go toward +inf.
  function automatic logic signed [PROD_W-1:0] round_shift(
    input logic signed [PROD_W-1:0] prod,
    input logic [3:0]               sh
  );
    logic signed [PROD_W-1:0] bias;
    if (sh == 4'd0) bias = '0;
    else            bias = PROD_W'(1) << (sh - 4'd1);
    return (prod + bias) >>> sh;
  endfunction

  function automatic logic is_sat(input logic signed [SUM_W-1:0] v);
    return (v < QMIN_S) || (v > QMAX_S);
  endfunction

  // Result always lies within [QMIN, QMAX], so its low DATA_W bits are the
  // sign-extended value.
  function automatic logic signed [DATA_W-1:0] sat_clamp(input logic signed [SUM_W-1:0] v);
    if (v < QMIN_S) return DATA_W'(QMIN);
    if (v > QMAX_S) return DATA_W'(QMAX);
    return v[DATA_W-1:0];
  endfunction

  logic                     vld_p0, vld_p1, vld_p2;
  logic                     adv_p0, adv_p1, adv_p2;
  logic signed [PROD_W-1:0] prod_d, prod_p0;
  logic        [3:0]        shift_p0;
  logic signed [DATA_W-1:0] zp_p0, zp_p1;
  logic signed [PROD_W-1:0] rnd_d, rnd_p1;
  logic signed [SUM_W-1:0]  off_d;
  logic signed [DATA_W-1:0] clamp_d;
  logic                     sat_d;

  assign adv_p2   = !vld_p2 || ready_out;
  assign adv_p1   = !vld_p1 || adv_p2;
  assign adv_p0   = !vld_p0 || adv_p1;
  assign ready_in = adv_p0;
  assign valid_out = vld_p2;
  assign busy     = vld_p0 || vld_p1 || vld_p2;

  // scale_recip is unsigned: a zero MSB keeps it positive in the signed product.
  assign prod_d  = PROD_W'(signed'(data_in)) * PROD_W'(signed'({1'b0, scale_recip}));
  assign rnd_d   = round_shift(prod_p0, shift_p0);
  assign off_d   = SUM_W'(rnd_p1) + SUM_W'(zp_p1);
  assign clamp_d = sat_clamp(off_d);
  assign sat_d   = is_sat(off_d);

  // S1/S2 datapath registers: no reset, qualified by the stage valids.
  always_ff @(posedge clk) begin
    // ---- S1: multiply, capture per-item config ----
    if (adv_p0 && valid_in) begin
      prod_p0  <= prod_d;
      shift_p0 <= shift;
      zp_p0    <= signed'(zero_point);
    end
    // ---- S2: round and shift ----
    if (adv_p1 && vld_p0) begin
      rnd_p1 <= rnd_d;
      zp_p1  <= zp_p0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      data_out  <= '0;
      sat_out   <= 1'b0;
      sat_count <= '0;
    end else begin
      if (adv_p0) vld_p0 <= valid_in;
      if (adv_p1) vld_p1 <= vld_p0;
      // ---- S3: zero-point offset and clamp, drives the output port ----
      if (adv_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          data_out <= clamp_d;
          sat_out  <= sat_d;
        end
      end
      if (sat_clear)
        sat_count <= '0;
      else if (vld_p2 && ready_out && sat_out && (sat_count != 16'hFFFF))
        sat_count <= sat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_quantization_unit.sv
module tb_quantization_unit;

  localparam int QMIN = -128;
  localparam int QMAX = 127;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic        valid_in;
  logic        ready_in;
  logic [15:0] scale_recip;
  logic [3:0]  shift;
  logic [15:0] zero_point;
  logic [15:0] data_out;
  logic        valid_out;
  logic        ready_out;
  logic        sat_out;
  logic [15:0] sat_count;
  logic        sat_clear;
  logic        busy;

  quantization_unit #(.QMIN(QMIN), .QMAX(QMAX)) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
    .scale_recip(scale_recip), .shift(shift), .zero_point(zero_point),
    .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out),
    .sat_out(sat_out), .sat_count(sat_count), .sat_clear(sat_clear),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Values seen just before the rising edge of the last step().
  logic        in_acc, out_acc, rin, bsy;
  logic [15:0] got;
  logic        gsat;
  int          exp_cnt;

  typedef struct {
    logic [15:0] din;
    logic [15:0] scale;
    logic [3:0]  sh;
    logic [15:0] zp;
    logic [15:0] exp_out;
    logic        exp_sat;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: real-valued floor of (x*s + 2^(sh-1)) / 2^sh, offset, clamp.
  function automatic logic [16:0] model(input logic [15:0] d, input logic [15:0] s,
                                        input logic [3:0] sh, input logic [15:0] z);
    longint p, den, q, v;
    p = longint'($signed(d)) * longint'({16'd0, s});
    den = longint'(1) << sh;
    if (sh != 0) p = p + den / 2;
    q = p / den;
    if (p < 0 && (p % den) != 0) q = q - 1;
    v = q + longint'($signed(z));
    if (v < QMIN) return {1'b1, 16'(QMIN)};
    if (v > QMAX) return {1'b1, 16'(QMAX)};
    return {1'b0, 16'(v)};
  endfunction

  task automatic step();
    #1;
    in_acc  = valid_in && ready_in;
    out_acc = valid_out && ready_out;
    got     = data_out;
    gsat    = sat_out;
    rin     = ready_in;
    bsy     = busy;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sends one item into an empty pipe and waits for it; lat=0 on timeout.
  task automatic send(input logic [15:0] d, input logic [15:0] s, input logic [3:0] h,
                      input logic [15:0] z, input logic clr, output int lat);
    data_in = d; scale_recip = s; shift = h; zero_point = z;
    valid_in = 1'b1; ready_out = 1'b1;
    step();
    check("send_accept", in_acc, 1'b1);
    valid_in = 1'b0;
    data_in = 16'($urandom); shift = 4'($urandom); zero_point = 16'($urandom);
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      sat_clear = clr && valid_out;
      step();
      sat_clear = 1'b0;
      if (out_acc) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          nout;
    logic [16:0] m;
    logic [16:0] q[$];
    logic [15:0] bp_d[4];

    tbl[0]  = '{16'd100,    16'h4000, 4'd15, 16'd3,    16'h0035, 1'b0};
    tbl[1]  = '{16'hFFFD,   16'd1,    4'd1,  16'd0,    16'hFFFF, 1'b0};
    tbl[2]  = '{16'h7FFF,   16'hFFFF, 4'd0,  16'd0,    16'h007F, 1'b1};
    tbl[3]  = '{16'h8000,   16'hFFFF, 4'd0,  16'd0,    16'hFF80, 1'b1};
    tbl[4]  = '{16'd10,     16'd1,    4'd2,  16'd0,    16'h0003, 1'b0};
    tbl[5]  = '{16'hFFF6,   16'd1,    4'd2,  16'd0,    16'hFFFE, 1'b0};
    tbl[6]  = '{16'd0,      16'd0,    4'd0,  16'hFFFB, 16'hFFFB, 1'b0};
    tbl[7]  = '{16'd1,      16'd200,  4'd0,  16'hFF9C, 16'h0064, 1'b0};
    tbl[8]  = '{16'd127,    16'd1,    4'd0,  16'd0,    16'h007F, 1'b0};
    tbl[9]  = '{16'd128,    16'd1,    4'd0,  16'd0,    16'h007F, 1'b1};
    tbl[10] = '{16'hFF7F,   16'd1,    4'd0,  16'd0,    16'hFF80, 1'b1};

    rst = 1'b1; valid_in = 1'b0; ready_out = 1'b0; sat_clear = 1'b0;
    data_in = '0; scale_recip = '0; shift = '0; zero_point = '0;
    repeat (2) @(negedge clk);
    check("rst_valid_out", valid_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data_out", data_out, 16'h0);
    check("rst_sat_out", sat_out, 1'b0);
    check("rst_sat_count", sat_count, 16'h0);
    rst = 1'b0;
    #1 check("post_rst_ready_in", ready_in, 1'b1);
    @(negedge clk);

    // Directed table
    exp_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      send(tbl[i].din, tbl[i].scale, tbl[i].sh, tbl[i].zp, 1'b0, lat);
      check($sformatf("tbl%0d_latency", i), lat, 3);
      check($sformatf("tbl%0d_data", i), got, tbl[i].exp_out);
      check($sformatf("tbl%0d_sat", i), gsat, tbl[i].exp_sat);
      if (tbl[i].exp_sat) exp_cnt++;
      check($sformatf("tbl%0d_sat_count", i), sat_count, exp_cnt);
    end

    // Backpressure: three items fill the pipe, the fourth waits
    ready_out = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bp_d[k] = 16'(k * 7 + 1);
      data_in = bp_d[k]; scale_recip = 16'd3; shift = 4'd1; zero_point = 16'(k);
      valid_in = 1'b1;
      if (k < 3) begin
        step();
        check($sformatf("bp_accept%0d", k), in_acc, 1'b1);
      end else begin
        #1 check("bp_full_ready_in", ready_in, 1'b0);
      end
    end
    ready_out = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) begin
        check("bp_accept3", in_acc, 1'b1);
        valid_in = 1'b0;
      end
      m = model(bp_d[k], 16'd3, 4'd1, 16'(k));
      check($sformatf("bp_out_vld%0d", k), out_acc, 1'b1);
      check($sformatf("bp_out_data%0d", k), got, m[15:0]);
    end
    step();
    check("bp_drained", bsy, 1'b0);

    // Reset with two items in flight
    ready_out = 1'b0;
    data_in = 16'd9; scale_recip = 16'd1; shift = 4'd0; zero_point = 16'd0;
    valid_in = 1'b1;
    step(); step();
    valid_in = 1'b0;
    #1 check("mid_busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid_out", valid_out, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_sat_count", sat_count, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    #1 check("mid_rst_ready_in", ready_in, 1'b1);
    data_in = 16'd50; scale_recip = 16'd2; shift = 4'd1; zero_point = 16'hFFFF;
    valid_in = 1'b1; ready_out = 1'b1;
    step();
    valid_in = 1'b0;
    nout = 0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (out_acc) begin
        nout++;
        if (nout == 1) check("mid_rst_first_out", got, 16'd49);
      end
    end
    check("mid_rst_out_count", nout, 1);

    // sat_clear wins over a coincident saturated transfer
    send(16'h7FFF, 16'hFFFF, 4'd0, 16'd0, 1'b0, lat);
    check("clr_pre_sat", gsat, 1'b1);
    check("clr_pre_count", sat_count, 16'd1);
    send(16'h8000, 16'hFFFF, 4'd0, 16'd0, 1'b1, lat);
    check("clr_out_sat", gsat, 1'b1);
    check("clr_count", sat_count, 16'd0);
    exp_cnt = 0;

    // Random traffic against the reference queue
    for (int c = 0; c < 400; c++) begin
      valid_in    = ($urandom_range(0, 9) < 7);
      data_in     = 16'($urandom);
      scale_recip = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 300));
      shift       = 4'($urandom);
      zero_point  = 16'($signed($urandom_range(0, 200)) - 100);
      ready_out   = ($urandom_range(0, 9) < 7);
      sat_clear   = ($urandom_range(0, 19) == 0);
      step();
      check("rnd_busy", bsy, (q.size() != 0));
      check("rnd_ready_in", rin, !(q.size() == 3 && !ready_out));
      if (out_acc) begin
        if (q.size() == 0) begin
          check("rnd_unexpected_out", 1'b1, 1'b0);
        end else begin
          m = q.pop_front();
          check("rnd_data", got, m[15:0]);
          check("rnd_sat", gsat, m[16]);
          if (!sat_clear && m[16] && exp_cnt != 16'hFFFF) exp_cnt++;
        end
      end
      if (sat_clear) exp_cnt = 0;
      if (in_acc) q.push_back(model(data_in, scale_recip, shift, zero_point));
      check("rnd_sat_count", sat_count, exp_cnt);
    end
    valid_in = 1'b0; ready_out = 1'b1; sat_clear = 1'b0;
    for (int n = 0; n < 10 && q.size() != 0; n++) begin
      step();
      if (out_acc) begin
        m = q.pop_front();
        check("drain_data", got, m[15:0]);
        check("drain_sat", gsat, m[16]);
      end
    end
    check("drain_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quantization_unit.md
QUANTIZATION_UNIT -- requirements
Module: quantization_unit

Interface
REQ-001 SHALL have parameter QMIN, default -128, lowest representable quantized value (signed).
REQ-002 SHALL have parameter QMAX, default 127, highest representable quantized value (signed); QMIN < QMAX.
REQ-003 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: data_in  input  16  signed fixed-point sample to quantize.
REQ-006 SHALL have port: valid_in  input  1  data_in valid.
REQ-007 SHALL have port: ready_in  output  1  unit can accept data_in this cycle.
REQ-008 SHALL have port: scale_recip  input  16  unsigned reciprocal-scale multiplier.
REQ-009 SHALL have port: shift  input  4  right-shift amount, 0..15.
REQ-010 SHALL have port: zero_point  input  16  signed zero point.
REQ-011 SHALL have port: data_out  output  16  quantized result, sign-extended to 16 bits.
REQ-012 SHALL have port: valid_out  output  1  data_out valid.
REQ-013 SHALL have port: ready_out  input  1  downstream accepts data_out.
REQ-014 SHALL have port: sat_out  output  1  current data_out was clamped.
REQ-015 SHALL have port: sat_count  output  16  count of clamped results delivered.
REQ-016 SHALL have port: sat_clear  input  1  synchronous clear of sat_count.
REQ-017 SHALL have port: busy  output  1  any pipeline stage holds a valid item.

Function
REQ-018 Transfer on a port SHALL occur only on a rising edge where valid and ready are both 1.
REQ-019 Pipeline SHALL have three register stages S1 (multiply), S2 (round/shift), S3 (offset/clamp, drives data_out/valid_out/sat_out), each with its own valid bit.
REQ-020 S1 SHALL capture data_in*scale_recip as 33-bit signed product (data_in signed, scale_recip zero-extended), plus shift and zero_point of the same transfer; later config changes SHALL NOT affect in-flight items.
REQ-021 S2 SHALL compute (product + (shift==0 ? 0 : 1<<(shift-1))) arithmetic-shifted right by shift (round half toward +infinity), 33-bit signed.
REQ-022 S3 SHALL add sign-extended zero_point in 34-bit signed, clamp to [QMIN,QMAX], set sat_out=1 iff clamping changed the value.
REQ-023 Stage advance: s3_adv = !s3_v | ready_out; s2_adv = !s2_v | s3_adv; s1_adv = !s1_v | s2_adv; ready_in = s1_adv (combinational path from ready_out permitted).
REQ-024 A stage not advancing SHALL hold its contents unchanged; a stage advancing with no incoming item SHALL clear its valid.
REQ-025 Latency: item accepted at edge k SHALL be on data_out with valid_out=1 after edge k+2 when unstalled; throughput one item per cycle.
REQ-026 With ready_out=0 the unit SHALL hold at most 3 items, then deassert ready_in; no item SHALL be dropped or duplicated.
REQ-027 sat_count SHALL increment by 1 on each output transfer with sat_out=1, saturating at 0xFFFF.
REQ-028 sat_clear SHALL force sat_count to 0 on that edge, taking priority over a simultaneous increment.
REQ-029 busy SHALL equal s1_v | s2_v | s3_v.

Reset
REQ-030 While rst=1, SHALL clear all stage valids, data_out=0, sat_out=0, sat_count=0, valid_out=0, busy=0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight items; first post-reset output SHALL come from the first post-reset transfer.
REQ-032 After reset release with pipeline empty, ready_in SHALL be 1 regardless of ready_out.

Verification
REQ-033 data_in=100, scale_recip=0x4000, shift=15, zero_point=3, ready_out=1 -> data_out=0x0035 two edges after acceptance, sat_out=0.
REQ-034 data_in=-3 (0xFFFD), scale_recip=1, shift=1, zero_point=0 -> data_out=0xFFFF (-1.5 rounds to -1), sat_out=0.
REQ-035 data_in=0x7FFF, scale_recip=0xFFFF, shift=0, zero_point=0 -> data_out=0x007F, sat_out=1, sat_count 0->1; same with data_in=0x8000 -> 0xFF80.
REQ-036 ready_out=0, offer 4 back-to-back items -> 3 accepted, ready_in=0 on 4th; release ready_out -> all 4 delivered in order, one per cycle.
REQ-037 Fill 2 items, pulse rst for one cycle -> valid_out=0, busy=0, sat_count=0; next item emerges alone with correct value.
REQ-038 sat_clear coincident with saturated output transfer -> sat_count=0 after that edge.
